// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// master: the operand producer / result consumer; slave: the adder.
interface pipe_addsub_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, x, y, cin, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );

   modport slave (
      input  in_valid, x, y, cin, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit chunk per stage, chunk carry
// registered between stages, global stall, valid/ready on both sides.
module pipe_addsub #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input logic          clk,
   input logic          rst_n,
   pipe_addsub_if.slave addsub_io
);
   localparam int unsigned CW = WIDTH / STAGES;

   // Reject geometries that cannot be split into equal chunks.
   if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_geometry
      $error("pipe_addsub: WIDTH must be a nonzero multiple of STAGES");
   end

   // Per-stage state: operands still to be consumed, result chunks produced so
   // far, chunk carry and valid bit. Stage STAGES-1 is the output register.
   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  r_q [STAGES];
   logic [WIDTH-1:0]  r_d [STAGES];
   logic              ovf_q, ovf_d;
   logic [CW:0]       sum;
   logic              advance_c;

   // Chunk k of a + b + ci, with the chunk carry-out as the top bit.
   function automatic logic [CW:0] chunk_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input int unsigned      k,
                                             input logic             ci);
      return {1'b0, a[k*CW +: CW]} + {1'b0, b[k*CW +: CW]} + (CW+1)'(ci);
   endfunction

   // Whole pipeline moves when the output slot is empty or being drained.
   always_comb begin
      advance_c = ~v_q[STAGES-1] | addsub_io.out_ready;
   end

   // Next state of every stage; everything holds while stalled.
   always_comb begin
      v_d   = v_q;
      c_d   = c_q;
      a_d   = a_q;
      b_d   = b_q;
      r_d   = r_q;
      ovf_d = ovf_q;
      sum   = '0;
      if (advance_c) begin
         // Stage 0 captures operands; y is inverted here, once, for subtract.
         a_d[0] = addsub_io.x;
         b_d[0] = addsub_io.sub ? ~addsub_io.y : addsub_io.y;
         r_d[0] = '0;
         v_d[0] = addsub_io.in_valid;
         sum    = chunk_add(a_d[0], b_d[0], 0,
                            addsub_io.sub ? ~addsub_io.cin : addsub_io.cin);
         r_d[0][CW-1:0] = sum[CW-1:0];
         c_d[0]         = sum[CW];
         // Later stages add their chunk using the carry registered upstream.
         for (int unsigned k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            r_d[k] = r_q[k-1];
            v_d[k] = v_q[k-1];
            sum    = chunk_add(a_q[k-1], b_q[k-1], k, c_q[k-1]);
            r_d[k][k*CW +: CW] = sum[CW-1:0];
            c_d[k]             = sum[CW];
         end
         // Carry into the MSB is a^b^s at that bit; overflow compares it to cout.
         ovf_d = a_d[STAGES-1][WIDTH-1] ^ b_d[STAGES-1][WIDTH-1]
               ^ r_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
      end
   end

   // Pipeline registers; reset discards in-flight transactions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            r_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         c_q   <= c_d;
         ovf_q <= ovf_d;
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            r_q[k] <= r_d[k];
         end
      end
   end

   // Output side is the last stage register; in_ready follows the stall term.
   assign addsub_io.in_ready  = advance_c;
   assign addsub_io.out_valid = v_q[STAGES-1];
   assign addsub_io.s         = r_q[STAGES-1];
   assign addsub_io.cout      = c_q[STAGES-1];
   assign addsub_io.ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: three geometries (8/4, 32/4, 16/1) driven one at a
// time from a single directed sequence, with a scoreboard queue of expectations.
module tb_pipe_addsub;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [2:0]  in_valid_t, cin_t, sub_t, out_ready_t;
   logic [31:0] x_t [3];
   logic [31:0] y_t [3];
   wire  [2:0]  in_ready_w, out_valid_w, cout_w, ovf_w;
   wire  [31:0] s_w [3];

   int wd [3] = '{8, 32, 16};
   int st [3] = '{4, 4, 1};

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [33:0] exp_q [$];
   int          acc_q [$];
   bit          stall_q = 1'b0;
   bit          chk_lat = 1'b0;
   logic [31:0] sv_s;
   logic        sv_c, sv_o;
   bit          acc;

   pipe_addsub_if #(.WIDTH(8))  if0 ();
   pipe_addsub_if #(.WIDTH(32)) if1 ();
   pipe_addsub_if #(.WIDTH(16)) if2 ();

   assign if0.in_valid = in_valid_t[0];
   assign if0.x        = x_t[0][7:0];
   assign if0.y        = y_t[0][7:0];
   assign if0.cin      = cin_t[0];
   assign if0.sub      = sub_t[0];
   assign if0.out_ready = out_ready_t[0];
   assign in_ready_w[0] = if0.in_ready;
   assign out_valid_w[0] = if0.out_valid;
   assign cout_w[0]    = if0.cout;
   assign ovf_w[0]     = if0.ovf;
   assign s_w[0]       = 32'(if0.s);

   assign if1.in_valid = in_valid_t[1];
   assign if1.x        = x_t[1];
   assign if1.y        = y_t[1];
   assign if1.cin      = cin_t[1];
   assign if1.sub      = sub_t[1];
   assign if1.out_ready = out_ready_t[1];
   assign in_ready_w[1] = if1.in_ready;
   assign out_valid_w[1] = if1.out_valid;
   assign cout_w[1]    = if1.cout;
   assign ovf_w[1]     = if1.ovf;
   assign s_w[1]       = if1.s;

   assign if2.in_valid = in_valid_t[2];
   assign if2.x        = x_t[2][15:0];
   assign if2.y        = y_t[2][15:0];
   assign if2.cin      = cin_t[2];
   assign if2.sub      = sub_t[2];
   assign if2.out_ready = out_ready_t[2];
   assign in_ready_w[2] = if2.in_ready;
   assign out_valid_w[2] = if2.out_valid;
   assign cout_w[2]    = if2.cout;
   assign ovf_w[2]     = if2.ovf;
   assign s_w[2]       = 32'(if2.s);

   pipe_addsub #(.WIDTH(8),  .STAGES(4)) u0 (.clk(clk), .rst_n(rst_n), .addsub_io(if0));
   pipe_addsub #(.WIDTH(32), .STAGES(4)) u1 (.clk(clk), .rst_n(rst_n), .addsub_io(if1));
   pipe_addsub #(.WIDTH(16), .STAGES(1)) u2 (.clk(clk), .rst_n(rst_n), .addsub_io(if2));

   // Reference: {ovf, cout, s} of a w-bit add or subtract, built from full-width arithmetic.
   function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic c,
                                         input logic sb);
      logic [63:0] mask, aa, bb, full;
      logic [31:0] r;
      logic        ce, co, ov;
      mask = (64'd1 << w) - 64'd1;
      aa   = {32'd0, a} & mask;
      bb   = sb ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
      ce   = sb ? ~c : c;
      full = aa + bb + 64'(ce);
      r    = 32'(full & mask);
      co   = full[w];
      ov   = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
      return {ov, co, r};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle on DUT d: drive, sample at negedge, score, step past posedge.
   task automatic cycle(input int d, input bit v, input logic [31:0] a,
                        input logic [31:0] b, input logic c, input logic sb,
                        input bit ordy, output bit acc_o);
      logic [33:0] e;
      int          t;
      in_valid_t[d]  = v;
      x_t[d]         = a;
      y_t[d]         = b;
      cin_t[d]       = c;
      sub_t[d]       = sb;
      out_ready_t[d] = ordy;
      @(negedge clk);
      if (stall_q) begin
         check("hold_valid", 64'(out_valid_w[d]), 64'd1);
         check("hold_s",     64'(s_w[d]),        64'(sv_s));
         check("hold_cout",  64'(cout_w[d]),     64'(sv_c));
         check("hold_ovf",   64'(ovf_w[d]),      64'(sv_o));
      end
      check("in_ready", 64'(in_ready_w[d]), 64'(!out_valid_w[d] || ordy));
      if (out_valid_w[d] && ordy) begin
         if (exp_q.size() == 0) begin
            check("extra_out", 64'(out_valid_w[d]), 64'd0);
         end else begin
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            check("s",    64'(s_w[d]),    64'(e[31:0]));
            check("cout", 64'(cout_w[d]), 64'(e[32]));
            check("ovf",  64'(ovf_w[d]),  64'(e[33]));
            if (chk_lat) check("latency", 64'(cyc - t), 64'(st[d]));
         end
      end
      acc_o = v && in_ready_w[d];
      if (acc_o) begin
         exp_q.push_back(model(wd[d], a, b, c, sb));
         acc_q.push_back(cyc);
      end
      stall_q = out_valid_w[d] && !ordy;
      sv_s    = s_w[d];
      sv_c    = cout_w[d];
      sv_o    = ovf_w[d];
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // Drain outstanding results with out_ready high, bounded, then look for extras.
   task automatic drain(input int d);
      bit a;
      for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle(d, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) cycle(d, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
   endtask

   initial begin
      logic [31:0] va [6] = '{32'hFF, 32'h7F, 32'h80, 32'h05, 32'hA5, 32'h00};
      logic [31:0] vb [6] = '{32'h01, 32'h01, 32'h01, 32'h05, 32'h3C, 32'h00};
      logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] ra, rb;
      logic        rc, rs;
      int          n, guard;

      // Reset held with traffic offered and no downstream ready.
      rst_n       = 1'b0;
      in_valid_t  = '1;
      out_ready_t = '0;
      cin_t       = '0;
      sub_t       = '0;
      for (int d = 0; d < 3; d++) begin
         x_t[d] = $urandom;
         y_t[d] = $urandom;
      end
      #12;
      for (int d = 0; d < 3; d++) begin
         check("rst_out_valid", 64'(out_valid_w[d]), 64'd0);
         check("rst_s",         64'(s_w[d]),         64'd0);
         check("rst_cout",      64'(cout_w[d]),      64'd0);
         check("rst_ovf",       64'(ovf_w[d]),       64'd0);
         check("rst_in_ready",  64'(in_ready_w[d]),  64'd1);
      end
      in_valid_t  = '0;
      out_ready_t = '1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 8/4: lone all-ones + 1, then the directed vectors back to back.
      chk_lat = 1'b1;
      cycle(0, 1'b1, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b1, acc);
      check("first_accept", 64'(acc), 64'd1);
      drain(0);
      for (int i = 0; i < 6; i++) begin
         cycle(0, 1'b1, va[i], vb[i], vc[i], vs[i], 1'b1, acc);
         check("b2b_accept", 64'(acc), 64'd1);
      end
      drain(0);

      // 8/4: fill while stalled, hold, then release.
      chk_lat = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
         cycle(0, 1'b1, ra, rb, rc, rs, 1'b0, acc);
      end
      repeat (4) cycle(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      drain(0);

      // 16/1: single-stage latency and carry wrap.
      chk_lat = 1'b1;
      cycle(2, 1'b1, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 1'b1, acc);
      drain(2);
      cycle(2, 1'b1, 32'h8000, 32'h0001, 1'b0, 1'b1, 1'b1, acc);
      cycle(2, 1'b1, 32'h1234, 32'hF00D, 1'b1, 1'b1, 1'b1, acc);
      drain(2);

      // 32/4: 16 random transactions back to back with random backpressure.
      chk_lat = 1'b0;
      n = 0;
      guard = 0;
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      while (n < 16 && guard < 400) begin
         cycle(1, 1'b1, ra, rb, rc, rs, ($urandom % 4) != 0, acc);
         if (acc) begin
            n++;
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
         end
         guard++;
      end
      check("stream_accepted", 64'(n), 64'd16);
      drain(1);

      // 32/4: reset between edges with three transactions in flight.
      for (int i = 0; i < 3; i++) begin
         ra = $urandom; rb = $urandom;
         cycle(1, 1'b1, ra, rb, 1'b0, 1'b0, 1'b0, acc);
      end
      cycle(1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      check("pre_reset_valid", 64'(out_valid_w[1]), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid_w[1]), 64'd0);
      check("async_rst_s",     64'(s_w[1]),         64'd0);
      exp_q.delete();
      acc_q.delete();
      stall_q = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         cycle(1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
         check("no_stale", 64'(out_valid_w[1]), 64'd0);
      end
      chk_lat = 1'b1;
      cycle(1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, acc);
      cycle(1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, acc);
      drain(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
